// File: rtl/aes_pkg.sv
// Shared AES datapath types, the GF(2^8) reduction constant and the xtime helper
// used by the iterative (Inv)MixColumns engine.
package aes_pkg;

   typedef logic [127:0] state_t;
   typedef logic [31:0]  column_t;

   localparam logic [7:0] GF_POLY = 8'h1B;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } mc_fsm_t;

   // Multiply by x in GF(2^8), reducing by x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational single-column MixColumns / InvMixColumns; row 0 is the MSB byte.
module mix_column_unit
   import aes_pkg::*;
(
   input  column_t col_in,
   input  logic    inverse,
   output column_t col_out
);

   logic [7:0] a   [4];
   logic [7:0] m2  [4];
   logic [7:0] m3  [4];
   logic [7:0] m9  [4];
   logic [7:0] mb  [4];
   logic [7:0] md  [4];
   logic [7:0] me  [4];
   logic [7:0] res [4];

   // Inverse coefficients are built from the chained xtime powers x2, x4, x8.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         logic [7:0] x2;
         logic [7:0] x4;
         logic [7:0] x8;
         a[r]  = col_in[31-8*r -: 8];
         x2    = xtime(a[r]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m2[r] = x2;
         m3[r] = x2 ^ a[r];
         m9[r] = x8 ^ a[r];
         mb[r] = x8 ^ x2 ^ a[r];
         md[r] = x8 ^ x4 ^ a[r];
         me[r] = x8 ^ x4 ^ x2;
      end
   end

   always_comb begin
      if (inverse) begin
         res[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
         res[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
         res[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
         res[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
      end else begin
         res[0] = m2[0] ^ m3[1] ^ a[2]  ^ a[3];
         res[1] = a[0]  ^ m2[1] ^ m3[2] ^ a[3];
         res[2] = a[0]  ^ a[1]  ^ m2[2] ^ m3[3];
         res[3] = m3[0] ^ a[1]  ^ a[2]  ^ m2[3];
      end
   end

   assign col_out = {res[0], res[1], res[2], res[3]};

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative (Inv)MixColumns engine, COLS_PER_CYCLE columns per clock, valid/ready on both sides.
// Optional MIX_COLUMNS_BYPASS_EN adds in_bypass, which passes the state through unchanged.
module mix_columns_engine
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   in_valid,
   output logic   in_ready,
   input  state_t in_state,
   input  logic   in_inverse,
`ifdef MIX_COLUMNS_BYPASS_EN
   input  logic   in_bypass,
`endif
   output logic   out_valid,
   input  logic   out_ready,
   output state_t out_state,
   output logic   busy
);

   localparam int BEATS = 4 / COLS_PER_CYCLE;
   localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

   generate
      if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
         $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   mc_fsm_t    fsm_q, fsm_d;
   logic [1:0] cnt_q, cnt_d;
   logic       inv_q, inv_d;
   state_t     src_q, src_d;
   state_t     res_q, res_d;
   logic       bypass_now;

   column_t col_in  [COLS_PER_CYCLE];
   column_t col_out [COLS_PER_CYCLE];
   column_t col_res [COLS_PER_CYCLE];

`ifdef MIX_COLUMNS_BYPASS_EN
   logic bypass_q, bypass_d;
   assign bypass_now = bypass_q;
`else
   assign bypass_now = 1'b0;
`endif

   assign in_ready  = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
   assign out_valid = (fsm_q == DONE);
   assign busy      = (fsm_q == BUSY);
   assign out_state = res_q;

   // Select the columns belonging to the current beat from the captured state.
   always_comb begin
      for (int i = 0; i < COLS_PER_CYCLE; i++) begin
         col_in[i]  = src_q[127 - 32*(int'(cnt_q)*COLS_PER_CYCLE + i) -: 32];
         col_res[i] = bypass_now ? col_in[i] : col_out[i];
      end
   end

   generate
      for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
         mix_column_unit u_unit (
            .col_in  (col_in[g]),
            .inverse (inv_q),
            .col_out (col_out[g])
         );
      end
   endgenerate

   always_comb begin
      fsm_d = fsm_q;
      cnt_d = cnt_q;
      inv_d = inv_q;
      src_d = src_q;
      res_d = res_q;
`ifdef MIX_COLUMNS_BYPASS_EN
      bypass_d = bypass_q;
`endif
      case (fsm_q)
         IDLE: begin
            if (in_valid) fsm_d = BUSY;
         end
         BUSY: begin
            for (int i = 0; i < COLS_PER_CYCLE; i++) begin
               res_d[127 - 32*(int'(cnt_q)*COLS_PER_CYCLE + i) -: 32] = col_res[i];
            end
            if (cnt_q == LAST_BEAT) begin
               cnt_d = 2'd0;
               fsm_d = DONE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         DONE: begin
            if (out_ready) fsm_d = in_valid ? BUSY : IDLE;
         end
         default: fsm_d = IDLE;
      endcase

      // Capture happens in IDLE or on a back-to-back handshake in DONE.
      if (in_valid && in_ready) begin
         src_d = in_state;
         inv_d = in_inverse;
         cnt_d = 2'd0;
`ifdef MIX_COLUMNS_BYPASS_EN
         bypass_d = in_bypass;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q <= IDLE;
         cnt_q <= 2'd0;
         inv_q <= 1'b0;
         src_q <= '0;
         res_q <= '0;
      end else begin
         fsm_q <= fsm_d;
         cnt_q <= cnt_d;
         inv_q <= inv_d;
         src_q <= src_d;
         res_q <= res_d;
      end
   end

`ifdef MIX_COLUMNS_BYPASS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) bypass_q <= 1'b0;
      else     bypass_q <= bypass_d;
   end
`endif

endmodule

// File: doc/mix_columns_engine.md
Name: mix_columns_engine

Overview:
- Iterative, parametrised (Inv)MixColumns engine for the AES datapath; replaces the purely combinational forward and inverse column mixers.
- Accepts one 128-bit state per transaction over a valid/ready handshake, with a per-transaction mode bit (forward/inverse).
- Processes COLS_PER_CYCLE columns per clock and returns the result with valid/ready backpressure.
- Sits between ShiftRows/InvShiftRows and AddRoundKey in the round pipeline.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; any other value is an elaboration error.
- BEATS, 4/COLS_PER_CYCLE, localparam; compute cycles per state.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input state present.
- in_ready  output  1  engine can accept a state this cycle.
- in_state  input  128  column c occupies bits [127-32c -: 32]; row 0 is the MSB byte of each column.
- in_inverse  input  1  0 = MixColumns (02 03 01 01 circulant); 1 = InvMixColumns (0E 0B 0D 09 circulant).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_state  output  128  transformed state, same layout as in_state.
- busy  output  1  high in BUSY.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_state=0, busy=0, FSM=IDLE, beat counter=0. Reset asserted mid-transaction discards the transaction with no output.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid: latch in_state and in_inverse, counter=0, go to BUSY.
- BUSY: each cycle, transform columns [counter*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1] (column 0 = bits 127:96 first) into the result register; counter increments. On counter==BEATS-1, go to DONE and set out_valid.
- DONE: out_valid=1; out_state is stable until the handshake.
  - out_ready=0: hold.
  - out_ready=1 and in_valid=0: go to IDLE, out_valid=0.
  - out_ready=1 and in_valid=1 (back-to-back): accept the new state the same cycle and go to BUSY.
- in_ready = IDLE || (DONE && out_ready). This is combinational from out_ready; no combinational path from in_valid.
- Latency: accept on edge T gives out_valid high after edge T+BEATS (COLS_PER_CYCLE=4: 1 cycle; =1: 4 cycles).
- Throughput: one state per BEATS+1 cycles with out_ready held high.
- Arithmetic: GF(2^8), xtime = {b[6:0],0} XOR (b[7] ? 8'h1B : 0).
  - Inverse coefficients from chained xtime: 09=x8^x1, 0B=x8^x2^x1, 0D=x8^x4^x1, 0E=x8^x4^x2.
- Mode is captured at accept. in_inverse changes during BUSY are ignored.
- Inputs are ignored while in_ready=0.

Optional Feature:
- Macro MIX_COLUMNS_BYPASS_EN adds input port in_bypass (1 bit), captured at accept.
- With the macro and in_bypass=1: out_state = captured in_state unchanged (used for the first/last AES rounds), with identical latency and handshake.
- Without the macro: no port, and every transaction is transformed.

Decomposition:
- Package aes_pkg holds:
  - the state_t (128-bit) and column_t (32-bit) typedefs;
  - the GF_POLY=8'h1B constant;
  - the FSM state enum;
  - an xtime function.
- One sub-module, mix_column_unit: combinational 32-bit column plus inverse flag in, 32-bit column out, both modes.
- The engine instantiates COLS_PER_CYCLE copies of mix_column_unit.

Test Plan:
- Forward, COLS_PER_CYCLE=1: in_state=d4bf5d30e0b452aeb84111f11e2798e5 -> out_state=046681e5e0cb199a48f8d37a2806264c, out_valid exactly 4 cycles after accept.
- Inverse on 046681e5e0cb199a48f8d37a2806264c -> d4bf5d30e0b452aeb84111f11e2798e5; repeat with COLS_PER_CYCLE=2 (latency 2) and 4 (latency 1).
- Edge columns, forward: db135345 -> 8e4da1bc, c6c6c6c6 -> c6c6c6c6, d4d4d4d5 -> d5d5d7d6; zero state -> zero state.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_state stable, in_ready=0; then out_ready=1 with in_valid=1 -> same-cycle accept and next result correct.
- Reset asserted asynchronously in BUSY -> out_valid=0 immediately, in_ready=1; the next transaction computes correctly.
- MIX_COLUMNS_BYPASS_EN defined, in_bypass=1 -> out_state equals in_state with normal latency; random forward/inverse round-trip of 1000 states returns the original.
